// File: rtl/apb_fifo_bridge_if.sv
// APB master bus plus ALU result push port and bridge status outputs.
// Bridge side uses the master modport; the bus model/bench uses slave.
interface apb_fifo_bridge_if #(
    parameter int N     = 4,
    parameter int M     = 8,
    parameter int A     = 8,
    parameter int DEPTH = 4
);
    localparam int SW = (N > 1) ? $clog2(N) : 1;
    localparam int LW = $clog2(DEPTH) + 1;

    logic [A-1:0]  PADDR;
    logic [N-1:0]  PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [M-1:0]  PWDATA;
    logic          PREADY;
    logic          PSLVERR;

    logic [M-1:0]  i_data;
    logic [A-1:0]  i_addr;
    logic          i_data_ready;
    logic          i_alu_error;
    logic [SW-1:0] i_protocol_sel;

    logic          o_waiting;
    logic          o_transfer_done;
    logic          o_error;
    logic [LW-1:0] o_level;

    modport master (
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        input  PREADY, PSLVERR,
        input  i_data, i_addr, i_data_ready, i_alu_error, i_protocol_sel,
        output o_waiting, o_transfer_done, o_error, o_level
    );

    modport slave (
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        output PREADY, PSLVERR,
        output i_data, i_addr, i_data_ready, i_alu_error, i_protocol_sel,
        input  o_waiting, o_transfer_done, o_error, o_level
    );
endinterface

// File: rtl/apb_fifo_bridge.sv
// Buffers ALU results in a FIFO and writes them out as APB transfers.
// Define APB_BRIDGE_TIMEOUT_EN to abort ACCESS after TIMEOUT wait cycles.
module apb_fifo_bridge #(
    parameter int N       = 4,
    parameter int M       = 8,
    parameter int A       = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input logic PCLK,
    input logic PRESET,
    apb_fifo_bridge_if.master bus
);
    localparam int SW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;

    localparam logic [LW-1:0] FULL  = LW'(DEPTH);
    localparam logic [LW-1:0] ONE   = LW'(1);
    localparam logic [SW:0]   NSEL  = (SW+1)'(N);

    logic [M-1:0]  mem_data [DEPTH];
    logic [A-1:0]  mem_addr [DEPTH];
    logic [SW-1:0] mem_sel  [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] rd_next;
    logic [PW-1:0] ld_ptr;
    logic [LW-1:0] level;
    logic [1:0]    state;
    logic [N-1:0]  ld_oh;

    logic sel_ok;
    logic push_ok;
    logic push_rej;
    logic pop;
    logic done_ok;
    logic fail;
    logic timeout_hit;
    logic more;
    logic done_q;
    logic err_q;

    assign sel_ok   = {1'b0, bus.i_protocol_sel} < NSEL;
    assign push_ok  = bus.i_data_ready & ~bus.i_alu_error
                    & sel_ok & (level != FULL);
    assign push_rej = bus.i_data_ready & ~push_ok;

    assign pop      = (state == ACCESS) & (bus.PREADY | timeout_hit);
    assign done_ok  = (state == ACCESS) & bus.PREADY & ~bus.PSLVERR;
    assign fail     = pop & ~done_ok;
    assign more     = level > ONE;

    assign rd_next  = rd_ptr + 1'b1;
    // On completion the entry behind the head is next in line.
    assign ld_ptr   = (state == ACCESS) ? rd_next : rd_ptr;
    assign ld_oh    = {{(N-1){1'b0}}, 1'b1} << mem_sel[ld_ptr];

`ifdef APB_BRIDGE_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] wait_cnt;

    assign timeout_hit = (state == ACCESS) & ~bus.PREADY
                       & (wait_cnt == LAST);

    // Count consecutive ACCESS wait cycles; cleared outside waiting.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            wait_cnt <= '0;
        end else if ((state == ACCESS) && !bus.PREADY && !timeout_hit) begin
            wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Storage array; contents are don't-care until written.
    always_ff @(posedge PCLK) begin
        if (push_ok) begin
            mem_data[wr_ptr] <= bus.i_data;
            mem_addr[wr_ptr] <= bus.i_addr;
            mem_sel[wr_ptr]  <= bus.i_protocol_sel;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop cancel.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_next;
            end
            if (push_ok && !pop) begin
                level <= level + 1'b1;
            end else if (!push_ok && pop) begin
                level <= level - 1'b1;
            end
        end
    end

    // APB sequencer; bus outputs are registered and loaded on SETUP entry.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state       <= IDLE;
            bus.PSEL    <= '0;
            bus.PENABLE <= 1'b0;
            bus.PWRITE  <= 1'b0;
            bus.PADDR   <= '0;
            bus.PWDATA  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (level != '0) begin
                        state      <= SETUP;
                        bus.PSEL   <= ld_oh;
                        bus.PADDR  <= mem_addr[ld_ptr];
                        bus.PWDATA <= mem_data[ld_ptr];
                        bus.PWRITE <= 1'b1;
                    end
                end
                SETUP: begin
                    state       <= ACCESS;
                    bus.PENABLE <= 1'b1;
                end
                ACCESS: begin
                    if (pop) begin
                        bus.PENABLE <= 1'b0;
                        if (more) begin
                            state      <= SETUP;
                            bus.PSEL   <= ld_oh;
                            bus.PADDR  <= mem_addr[ld_ptr];
                            bus.PWDATA <= mem_data[ld_ptr];
                        end else begin
                            state      <= IDLE;
                            bus.PSEL   <= '0;
                            bus.PWRITE <= 1'b0;
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    bus.PSEL    <= '0;
                    bus.PENABLE <= 1'b0;
                    bus.PWRITE  <= 1'b0;
                end
            endcase
        end
    end

    // One-cycle result pulses for completed, failed or dropped work.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= done_ok;
            err_q  <= push_rej | fail;
        end
    end

    assign bus.o_transfer_done = done_q;
    assign bus.o_error         = err_q;
    assign bus.o_level         = level;
    assign bus.o_waiting       = (level == FULL);

endmodule

// File: tb/tb_apb_fifo_bridge.sv
// Bench for apb_fifo_bridge: directed scenarios then random traffic
// checked by a queue-based reference model in a separate monitor.
module tb_apb_fifo_bridge;
    localparam int N       = 4;
    localparam int M       = 8;
    localparam int A       = 8;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    typedef struct {
        logic [7:0] d;
        logic [7:0] a;
        logic [1:0] s;
    } ent_t;

    logic PCLK = 1'b0;
    logic PRESET = 1'b1;

    always #5 PCLK = ~PCLK;

    apb_fifo_bridge_if #(.N(N), .M(M), .A(A), .DEPTH(DEPTH)) bus ();

    apb_fifo_bridge #(
        .N(N), .M(M), .A(A), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .PCLK(PCLK),
        .PRESET(PRESET),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    ent_t exp_q[$];
    logic mon_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic drive(input logic r, input logic e, input logic [7:0] d,
                         input logic [7:0] a, input logic [1:0] s);
        bus.i_data_ready   = r;
        bus.i_alu_error    = e;
        bus.i_data         = d;
        bus.i_addr         = a;
        bus.i_protocol_sel = s;
    endtask

    // Monitor: model FIFO as a queue, judge pushes on the model level,
    // pop on observed completions, compare next-cycle outputs.
    initial begin : monitor
        logic have_exp;
        logic e_done;
        logic e_err;
        int   e_level;
        logic p_setup;
        logic p_wait;
        logic [7:0] p_addr;
        logic [7:0] p_data;
        logic [3:0] p_sel;
        int   lvl;
        logic comp;
        logic acc;
        ent_t f;
        have_exp = 1'b0;
        p_setup  = 1'b0;
        p_wait   = 1'b0;
        forever begin
            @(negedge PCLK);
            if (!mon_on) begin
                have_exp = 1'b0;
                p_setup  = 1'b0;
                p_wait   = 1'b0;
            end else begin
                if (have_exp) begin
                    chk("done", bus.o_transfer_done, e_done);
                    chk("error", bus.o_error, e_err);
                    chk("level", bus.o_level, e_level);
                    chk("waiting", bus.o_waiting, e_level == DEPTH);
                end
                if (p_setup || p_wait) begin
                    chk("access_penable", bus.PENABLE, 1);
                    chk("hold_addr", bus.PADDR, p_addr);
                    chk("hold_data", bus.PWDATA, p_data);
                    chk("hold_sel", bus.PSEL, p_sel);
                end
                lvl  = exp_q.size();
                comp = bus.PENABLE && bus.PREADY;
                if (comp) begin
                    if (lvl == 0) begin
                        chk("spurious_xfer", lvl, 1);
                    end else begin
                        f = exp_q.pop_front();
                        chk("xfer_addr", bus.PADDR, f.a);
                        chk("xfer_data", bus.PWDATA, f.d);
                        chk("xfer_sel", bus.PSEL, 4'b0001 << f.s);
                        chk("xfer_write", bus.PWRITE, 1);
                    end
                end
                acc = bus.i_data_ready && !bus.i_alu_error
                    && (bus.i_protocol_sel < N) && (lvl < DEPTH);
                if (acc) begin
                    exp_q.push_back('{d: bus.i_data, a: bus.i_addr,
                                      s: bus.i_protocol_sel});
                end
                e_done   = comp && !bus.PSLVERR;
                e_err    = (bus.i_data_ready && !acc) || (comp && bus.PSLVERR);
                e_level  = lvl + int'(acc) - int'(comp);
                have_exp = 1'b1;
                p_setup  = (bus.PSEL != 0) && !bus.PENABLE;
                p_wait   = bus.PENABLE && !bus.PREADY;
                p_addr   = bus.PADDR;
                p_data   = bus.PWDATA;
                p_sel    = bus.PSEL;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : stim
        logic [7:0] dv [5];
        drive(0, 0, 8'h00, 8'h00, 2'd0);
        bus.PREADY  = 1'b0;
        bus.PSLVERR = 1'b0;

        // Reset values
        tick();
        tick();
        chk("rst_level", bus.o_level, 0);
        chk("rst_psel", bus.PSEL, 0);
        chk("rst_penable", bus.PENABLE, 0);
        chk("rst_pwrite", bus.PWRITE, 0);
        chk("rst_paddr", bus.PADDR, 0);
        chk("rst_pwdata", bus.PWDATA, 0);
        chk("rst_waiting", bus.o_waiting, 0);
        chk("rst_done", bus.o_transfer_done, 0);
        chk("rst_error", bus.o_error, 0);
        PRESET = 1'b0;
        tick();

        // Single zero-wait transfer
        bus.PREADY = 1'b1;
        drive(1, 0, 8'h5A, 8'h10, 2'd2);
        tick();
        drive(0, 0, 8'h00, 8'h00, 2'd0);
        chk("t1_level1", bus.o_level, 1);
        chk("t1_idle_psel", bus.PSEL, 0);
        tick();
        chk("t1_setup_psel", bus.PSEL, 4'b0100);
        chk("t1_setup_pen", bus.PENABLE, 0);
        chk("t1_setup_paddr", bus.PADDR, 8'h10);
        chk("t1_setup_pwdata", bus.PWDATA, 8'h5A);
        chk("t1_setup_pwrite", bus.PWRITE, 1);
        tick();
        chk("t1_access_pen", bus.PENABLE, 1);
        chk("t1_access_psel", bus.PSEL, 4'b0100);
        chk("t1_access_pwdata", bus.PWDATA, 8'h5A);
        tick();
        chk("t1_done", bus.o_transfer_done, 1);
        chk("t1_level0", bus.o_level, 0);
        chk("t1_end_psel", bus.PSEL, 0);
        chk("t1_end_pen", bus.PENABLE, 0);
        tick();
        chk("t1_done_pulse", bus.o_transfer_done, 0);

        // Fill to full with PREADY low, fifth push dropped
        bus.PREADY = 1'b0;
        for (int i = 0; i < 5; i++) begin
            dv[i] = 8'(8'h11 * (i + 1));
            drive(1, 0, dv[i], 8'(8'h40 + i), 2'(i));
            tick();
            chk("t2_level", bus.o_level, (i < 4) ? i + 1 : 4);
            chk("t2_waiting", bus.o_waiting, (i >= 3) ? 1 : 0);
            chk("t2_error", bus.o_error, (i == 4) ? 1 : 0);
        end
        drive(0, 0, 8'h00, 8'h00, 2'd0);
        tick();
        chk("t2_error_pulse", bus.o_error, 0);
        chk("t2_head_pen", bus.PENABLE, 1);
        chk("t2_head_paddr", bus.PADDR, 8'h40);
        bus.PREADY = 1'b1;
        for (int j = 0; j < 4; j++) begin
            tick();
            chk("t2_done", bus.o_transfer_done, 1);
            chk("t2_drain_level", bus.o_level, 3 - j);
            if (j < 3) begin
                chk("t2_b2b_pen", bus.PENABLE, 0);
                chk("t2_b2b_paddr", bus.PADDR, 8'(8'h40 + j + 1));
                chk("t2_b2b_psel", bus.PSEL, 4'b0001 << (j + 1));
                tick();
                chk("t2_b2b_access", bus.PENABLE, 1);
                chk("t2_b2b_pwdata", bus.PWDATA, dv[j+1]);
            end else begin
                chk("t2_last_psel", bus.PSEL, 0);
            end
        end
        tick();

        // Wait states: three ACCESS cycles with PREADY low
        bus.PREADY = 1'b0;
        drive(1, 0, 8'hC3, 8'h33, 2'd1);
        tick();
        drive(0, 0, 8'h00, 8'h00, 2'd0);
        tick();
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t3_pen", bus.PENABLE, 1);
            chk("t3_paddr", bus.PADDR, 8'h33);
            chk("t3_pwdata", bus.PWDATA, 8'hC3);
            chk("t3_psel", bus.PSEL, 4'b0010);
            chk("t3_nodone", bus.o_transfer_done, 0);
        end
        bus.PREADY = 1'b1;
        tick();
        chk("t3_done", bus.o_transfer_done, 1);
        chk("t3_level", bus.o_level, 0);
        tick();

        // ALU error push is dropped
        drive(1, 1, 8'hEE, 8'h77, 2'd3);
        tick();
        drive(0, 0, 8'h00, 8'h00, 2'd0);
        chk("t4_error", bus.o_error, 1);
        chk("t4_level", bus.o_level, 0);
        tick();
        chk("t4_error_pulse", bus.o_error, 0);
        chk("t4_no_psel", bus.PSEL, 0);
        tick();
        chk("t4_no_psel2", bus.PSEL, 0);

        // Slave error on completion
        bus.PSLVERR = 1'b1;
        drive(1, 0, 8'h99, 8'h21, 2'd0);
        tick();
        drive(0, 0, 8'h00, 8'h00, 2'd0);
        tick();
        tick();
        tick();
        chk("t5_slverr_err", bus.o_error, 1);
        chk("t5_slverr_nodone", bus.o_transfer_done, 0);
        chk("t5_slverr_level", bus.o_level, 0);
        bus.PSLVERR = 1'b0;
        bus.PREADY  = 1'b0;
        tick();

        // Reset in the middle of ACCESS
        drive(1, 0, 8'h42, 8'h24, 2'd3);
        tick();
        drive(0, 0, 8'h00, 8'h00, 2'd0);
        tick();
        tick();
        chk("t5_in_access", bus.PENABLE, 1);
        PRESET = 1'b1;
        #1;
        chk("t5_rst_psel", bus.PSEL, 0);
        chk("t5_rst_pen", bus.PENABLE, 0);
        chk("t5_rst_level", bus.o_level, 0);
        tick();
        PRESET = 1'b0;
        tick();
        chk("t5_rel_done", bus.o_transfer_done, 0);
        chk("t5_rel_err", bus.o_error, 0);
        chk("t5_rel_psel", bus.PSEL, 0);
        bus.PREADY = 1'b1;
        drive(1, 0, 8'h17, 8'h71, 2'd1);
        tick();
        drive(0, 0, 8'h00, 8'h00, 2'd0);
        chk("t5_restart_idle", bus.PSEL, 0);
        tick();
        chk("t5_restart_setup", bus.PSEL, 4'b0010);
        chk("t5_restart_addr", bus.PADDR, 8'h71);
        tick();
        tick();
        chk("t5_restart_done", bus.o_transfer_done, 1);

`ifdef APB_BRIDGE_TIMEOUT_EN
        // Timeout abort, next entry follows in SETUP
        bus.PREADY = 1'b0;
        tick();
        drive(1, 0, 8'hA1, 8'h50, 2'd0);
        tick();
        drive(1, 0, 8'hA2, 8'h51, 2'd3);
        tick();
        drive(0, 0, 8'h00, 8'h00, 2'd0);
        for (int k = 0; k < TIMEOUT; k++) begin
            chk("t6_waiting_access", bus.PENABLE, 1);
            tick();
        end
        chk("t6_abort_err", bus.o_error, 1);
        chk("t6_abort_nodone", bus.o_transfer_done, 0);
        chk("t6_next_setup", bus.PENABLE, 0);
        chk("t6_next_addr", bus.PADDR, 8'h51);
        chk("t6_next_sel", bus.PSEL, 4'b1000);
        chk("t6_level", bus.o_level, 1);
        bus.PREADY = 1'b1;
        tick();
        tick();
        chk("t6_next_done", bus.o_transfer_done, 1);
        tick();
`endif

        // Random traffic against the queue model
        PRESET = 1'b1;
        tick();
        PRESET = 1'b0;
        tick();
        mon_on = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            drive($urandom_range(1, 0) == 1,
                  $urandom_range(9, 0) == 0,
                  8'($urandom), 8'($urandom),
                  2'($urandom_range(3, 0)));
            bus.PREADY  = $urandom_range(9, 0) < 6;
            bus.PSLVERR = $urandom_range(4, 0) == 0;
            tick();
        end
        drive(0, 0, 8'h00, 8'h00, 2'd0);
        bus.PREADY  = 1'b1;
        bus.PSLVERR = 1'b0;
        for (int w = 0; w < 100; w++) begin
            if (exp_q.size() == 0 && bus.o_level == 0) break;
            tick();
        end
        tick();
        tick();
        chk("drain_level", bus.o_level, 0);
        chk("drain_queue", exp_q.size(), 0);
        mon_on = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
